// File: rtl/buffer.sv
// First-word-fall-through FIFO between the sample-capture front end and
// downstream processing; head word is always presented on data_out.
module buffer #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_read
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             do_wr, do_rd;

  // A full FIFO refuses the write even when a pop happens on the same edge.
  assign do_wr = data_in_valid && (cnt_q != CNT_FULL);
  assign do_rd = data_out_read && (cnt_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ack_d  = do_wr;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= data_in;
  end

  assign data_in_ack    = ack_q;
  assign data_out_valid = (cnt_q != '0);
  assign data_out       = data_out_valid ? mem_q[rptr_q] : '0;

endmodule

// File: tb/tb_buffer.sv
// Self-checking bench for buffer: vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_buffer;

  localparam int W = 9;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ack;
  logic [W-1:0] data_out;
  logic         data_out_valid;
  logic         data_out_read = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ack    (data_in_ack),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_read  (data_out_read)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [W-1:0] din;
    logic         rd;
    logic         e_ack;
    logic         e_vld;
    logic [W-1:0] e_dout;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_read = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic a, input logic v,
                         input logic [W-1:0] d);
    chk({nm, ".ack"}, int'(data_in_ack), int'(a));
    chk({nm, ".valid"}, int'(data_out_valid), int'(v));
    chk({nm, ".data"}, int'(data_out), int'(d));
  endtask

  int acks;
  int q[$];
  int next_in, next_out, cyc;
  logic e_wr, e_rd;

  initial begin
    vt[0] = '{1'b1, 9'h1FF, 1'b0, 1'b1, 1'b1, 9'h1FF};
    vt[1] = '{1'b1, 9'h00F, 1'b0, 1'b1, 1'b1, 9'h1FF};
    vt[2] = '{1'b1, 9'h003, 1'b0, 1'b1, 1'b1, 9'h1FF};
    vt[3] = '{1'b1, 9'h183, 1'b1, 1'b1, 1'b1, 9'h00F};
    vt[4] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h003};
    vt[5] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h183};
    vt[6] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000};
    vt[7] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000};

    // reset and idle read
    #2;
    chk_out("reset", 1'b0, 1'b0, '0);
    do_reset();
    data_out_read = 1'b1;
    step();
    chk_out("empty_read", 1'b0, 1'b0, '0);
    data_out_read = 1'b0;

    // burst / simultaneous read-write table
    for (int i = 0; i < 8; i++) begin
      data_in_valid = vt[i].vld;
      data_in       = vt[i].din;
      data_out_read = vt[i].rd;
      step();
      chk_out($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_vld,
              vt[i].e_dout);
    end
    data_out_read = 1'b0;

    // fill to the boundary
    acks = 0;
    data_in_valid = 1'b1;
    data_in = 9'h183;
    for (int i = 0; i < D + 3; i++) begin
      step();
      if (data_in_ack) acks++;
    end
    chk("fill.acks", acks, D);
    chk_out("fill.refused", 1'b0, 1'b1, 9'h183);
    data_out_read = 1'b1;
    step();
    chk_out("full_pop", 1'b0, 1'b1, 9'h183);
    data_out_read = 1'b0;
    step();
    chk_out("after_pop_write", 1'b1, 1'b1, 9'h183);
    data_in_valid = 1'b0;
    step();
    chk("after_pop_idle_ack", int'(data_in_ack), 0);

    // reset with 5 words queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      data_in_valid = 1'b1;
      data_in = W'(9'h10 + i);
      step();
    end
    data_in_valid = 1'b0;
    chk("pre_rst.valid", int'(data_out_valid), 1);
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    data_in_valid = 1'b1;
    data_in = 9'h055;
    step();
    data_in_valid = 1'b0;
    chk_out("post_rst_head", 1'b1, 1'b1, 9'h055);

    // randomized wrap-around run against a queue model
    do_reset();
    q.delete();
    next_in = 0;
    next_out = 0;
    cyc = 0;
    while (next_out < 40 && cyc < 2000) begin
      data_in_valid = (next_in < 40) && ($urandom_range(0, 3) != 0);
      data_in       = W'(next_in);
      data_out_read = (cyc < 60) ? ($urandom_range(0, 4) == 0)
                                 : ($urandom_range(0, 1) == 1);
      e_wr = data_in_valid && (q.size() < D);
      e_rd = data_out_read && (q.size() > 0);
      if (e_rd) begin
        chk("rand.pop_order", int'(data_out), next_out);
        void'(q.pop_front());
        next_out++;
      end
      if (e_wr) begin
        q.push_back(next_in);
        next_in++;
      end
      step();
      chk("rand.ack", int'(data_in_ack), int'(e_wr));
      chk("rand.valid", int'(data_out_valid), int'(q.size() != 0));
      chk("rand.data", int'(data_out), (q.size() != 0) ? q[0] : 0);
      cyc++;
    end
    chk("rand.all_out", next_out, 40);
    data_in_valid = 1'b0;
    data_out_read = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
